// File: rtl/network_source.sv
// Packet-to-network decoder: turns SPK/RUN/SNC/CLR dispatch packets into net_run/net_sync/net_clear requests.
// Define SOURCE_ERR_EN to add the sticky src_err port (undefined opcode, bad SPK index, RUN 0 with waiting fires).

package dispatch_config;
  localparam int unsigned NUM_OPC   = 8;
  localparam int unsigned NUM_INP   = 6;
  localparam int unsigned PFX_WIDTH = $clog2(NUM_OPC);
  localparam int unsigned IDX_WIDTH = $clog2(NUM_INP);

  localparam logic [PFX_WIDTH-1:0] OPC_NOP = PFX_WIDTH'(0);
  localparam logic [PFX_WIDTH-1:0] OPC_SPK = PFX_WIDTH'(1);
  localparam logic [PFX_WIDTH-1:0] OPC_RUN = PFX_WIDTH'(2);
  localparam logic [PFX_WIDTH-1:0] OPC_SNC = PFX_WIDTH'(3);
  localparam logic [PFX_WIDTH-1:0] OPC_CLR = PFX_WIDTH'(4);
endpackage

module network_source
  import dispatch_config::*;
#(
  parameter int unsigned PKT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [PKT_WIDTH-1:0] src,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 net_run,
  output logic                 net_sync,
  output logic                 net_clear,
  input  logic                 net_ready,
  output logic [NUM_INP-1:0]   net_inp
`ifdef SOURCE_ERR_EN
  ,
  output logic                 src_err
`endif
);

  localparam int unsigned RUN_WIDTH = PKT_WIDTH - PFX_WIDTH;
  localparam int unsigned IDX_W     = (IDX_WIDTH == 0) ? 1 : IDX_WIDTH;
  localparam logic [IDX_W:0] NUM_INP_W = (IDX_W + 1)'(NUM_INP);

  typedef enum logic [1:0] {IDLE, RUNS, SYNC, CLRD} state_t;

  state_t                 state;
  logic [NUM_INP-1:0]     pending;
  logic [RUN_WIDTH-1:0]   run_cnt;

  logic [PFX_WIDTH-1:0]   opc;
  logic [RUN_WIDTH-1:0]   payload;
  logic [IDX_W-1:0]       idx;
  logic                   idx_ok;
  logic [NUM_INP-1:0]     spk_mask;
  logic                   accept;
  logic                   handshake;

  // With a single input the index field has no bits, so the index is implicitly zero.
  if (IDX_WIDTH == 0) begin : g_idx_implicit
    assign idx = '0;
  end else begin : g_idx_field
    assign idx = src[RUN_WIDTH-1 -: IDX_WIDTH];
  end

  always_comb begin
    opc       = src[PKT_WIDTH-1 -: PFX_WIDTH];
    payload   = src[RUN_WIDTH-1:0];
    idx_ok    = ({1'b0, idx} < NUM_INP_W);
    spk_mask  = idx_ok ? (NUM_INP'(1) << idx) : '0;
    accept    = src_valid && src_ready;
    handshake = net_ready && (net_run || net_sync || net_clear);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      src_ready <= 1'b1;
      net_run   <= 1'b0;
      net_sync  <= 1'b0;
      net_clear <= 1'b0;
      net_inp   <= '0;
      pending   <= '0;
      run_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (opc)
              OPC_SPK: pending <= pending | spk_mask;
              OPC_RUN: begin
                run_cnt <= payload;
                if (payload != '0) begin
                  state     <= RUNS;
                  src_ready <= 1'b0;
                  net_run   <= 1'b1;
                  net_inp   <= pending;
                end
              end
              OPC_SNC: begin
                state     <= SYNC;
                src_ready <= 1'b0;
                net_sync  <= 1'b1;
              end
              OPC_CLR: begin
                state     <= CLRD;
                src_ready <= 1'b0;
                net_clear <= 1'b1;
                pending   <= '0;
              end
              default: ;
            endcase
          end
        end
        RUNS: begin
          // Fires ride only on the first accepted network cycle; later cycles present zero.
          if (handshake) begin
            pending <= '0;
            net_inp <= '0;
            run_cnt <= run_cnt - RUN_WIDTH'(1);
            if (run_cnt == RUN_WIDTH'(1)) begin
              state     <= IDLE;
              src_ready <= 1'b1;
              net_run   <= 1'b0;
            end
          end
        end
        SYNC: begin
          if (handshake) begin
            state     <= IDLE;
            src_ready <= 1'b1;
            net_sync  <= 1'b0;
          end
        end
        CLRD: begin
          if (handshake) begin
            state     <= IDLE;
            src_ready <= 1'b1;
            net_clear <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          src_ready <= 1'b1;
          net_run   <= 1'b0;
          net_sync  <= 1'b0;
          net_clear <= 1'b0;
          net_inp   <= '0;
        end
      endcase
    end
  end

`ifdef SOURCE_ERR_EN
  logic undefined_opc;
  logic err_event;

  always_comb begin
    undefined_opc = !(opc inside {OPC_NOP, OPC_SPK, OPC_RUN, OPC_SNC, OPC_CLR});
    err_event     = accept && (undefined_opc
                               || ((opc == OPC_SPK) && !idx_ok)
                               || ((opc == OPC_RUN) && (payload == '0) && (pending != '0)));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      src_err <= 1'b0;
    end else if (err_event) begin
      src_err <= 1'b1;
    end
  end
`endif

endmodule
